mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort of any operation in flight.
REQ-005 mult_valid  input  1  request present.
REQ-006 mult_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 mult_op1  input  32  multiplicand.
REQ-008 mult_op2  input  32  multiplier.
REQ-009 mult_ready  output  1  block can accept a request (high only in IDLE).
REQ-010 product_valid  output  1  product is valid and held.
REQ-011 product_ack  input  1  consumer takes the product.
REQ-012 product  output  64  {hi,lo} result; undefined unless product_valid is high.

Function
REQ-013 Accept: a request SHALL be accepted on the edge where mult_valid=1, mult_ready=1 and flush=0.
REQ-014 On accept: latch |op1| into mcand and |op2| into lo, clear hi, counter=0, neg = mult_signed & (op1[31]^op2[31]).
- Magnitudes come from a dedicated ~x+1 negation; unsigned operands pass through unchanged.
REQ-015 States SHALL be IDLE, CALC, NEG_LO, NEG_HI and DONE.
REQ-016 IDLE -> CALC on accept; otherwise stay in IDLE.
REQ-017 CALC: each cycle, if lo[0]=1 then sum = hi + mcand (cin=0), else sum = hi.
- {cout,sum,lo} SHALL shift right by 1 into {hi,lo}; cout is forced to 0 when lo[0]=0.
- counter increments by 1.
REQ-018 CALC runs for exactly 32 cycles (counter 0..31); at counter=31 go to NEG_LO if neg=1, else to DONE.
REQ-019 NEG_LO: lo = ~lo + 0 + cin=1; the adder carry-out is registered as ncarry; go to NEG_HI.
REQ-020 NEG_HI: hi = ~hi + 0 + cin=ncarry; go to DONE.
REQ-021 DONE: product_valid=1 and product={hi,lo} held stable until product_ack=1; on product_ack go to IDLE.
REQ-022 Latency, counted from the accept edge to the first cycle with product_valid=1:
- 33 edges when neg=0.
- 35 edges when neg=1.
REQ-023 Every addition in CALC, NEG_LO and NEG_HI SHALL use one shared 32-bit adder instance; no second 32-bit adder is allowed.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge and deassert product_valid; flush has priority over accept and over product_ack.
REQ-025 A request presented while mult_ready=0 SHALL be ignored, not queued.
REQ-026 product_ack while product_valid=0 SHALL have no effect.
REQ-027 Boundary: signed 0x80000000 SHALL be treated as magnitude 2^31, so signed -2^31 * -2^31 = 0x4000000000000000.
REQ-028 A zero operand SHALL still take the full 32 CALC cycles (no early exit).

Reset
REQ-029 While rst=1 and after release:
- state=IDLE, mult_ready=1, product_valid=0.
- product, hi, lo, mcand, counter, neg and ncarry all 0.
REQ-030 rst asserted mid-operation SHALL abandon the operation immediately, with no product_valid pulse afterwards.

Structure
REQ-031 A shared header/package SHALL hold:
- MULT_W=32 and CNT_W=5.
- State encodings for IDLE, CALC, NEG_LO, NEG_HI and DONE.
REQ-032 Exactly one sub-module SHALL be instantiated: the team 32-bit carry-lookahead adder, with ports operand1, operand2, cin, result and cout.
REQ-033 Adder inputs SHALL be driven by a state-muxed combinational block; all other logic lives in mult_seq.

Verification
REQ-034 Unsigned: op1=0x0000000A, op2=0x00000003, signed=0 -> product=0x000000000000001E, product_valid 33 edges after accept.
REQ-035 Unsigned max: op1=op2=0xFFFFFFFF, signed=0 -> product=0xFFFFFFFE00000001.
REQ-036 Signed negative: op1=0xFFFFFFFE (-2), op2=0x00000003, signed=1 -> product=0xFFFFFFFFFFFFFFFA, product_valid 35 edges after accept.
REQ-037 Signed corner: op1=op2=0x80000000, signed=1 -> product=0x4000000000000000 (neg=0, 33 edges).
REQ-038 Handshake: hold product_ack=0 for 10 cycles after product_valid -> product stable, mult_ready=0 throughout; ack -> mult_ready=1 on the next cycle.
REQ-039 Abort: flush at counter=15 -> IDLE next edge, with no product_valid. Assert rst during NEG_LO -> all outputs at reset values. A new request then completes correctly.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared widths, state encoding and operand helpers for the sequential
// shift-add multiplier.
package mult_seq_pkg;

    localparam int MULT_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_NEG_LO = 3'd2,
        ST_NEG_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
    function automatic logic [MULT_W-1:0] magnitude(input logic [MULT_W-1:0] x,
                                                    input logic               is_signed);
        if (is_signed && x[MULT_W-1])
            return ~x + MULT_W'(1);
        else
            return x;
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/product handshake bundle between a requester (master) and the
// multiplier (slave).
interface mult_seq_if;
    import mult_seq_pkg::*;

    logic              flush;
    logic              mult_valid;
    logic              mult_signed;
    logic [MULT_W-1:0] mult_op1;
    logic [MULT_W-1:0] mult_op2;
    logic              mult_ready;
    logic              product_valid;
    logic              product_ack;
    logic [2*MULT_W-1:0] product;

    modport master (
        output flush, mult_valid, mult_signed, mult_op1, mult_op2, product_ack,
        input  mult_ready, product_valid, product
    );

    modport slave (
        input  flush, mult_valid, mult_signed, mult_op1, mult_op2, product_ack,
        output mult_ready, product_valid, product
    );

endinterface

// File: rtl/mult_seq_cla.sv
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups with a
// group-level carry chain.
module mult_seq_cla
    import mult_seq_pkg::*;
(
    input  logic [MULT_W-1:0] operand1,
    input  logic [MULT_W-1:0] operand2,
    input  logic              cin,
    output logic [MULT_W-1:0] result,
    output logic              cout
);

    localparam int NGRP = MULT_W / 4;

    logic [MULT_W-1:0] g;
    logic [MULT_W-1:0] p;
    logic [MULT_W-1:0] c;
    logic [NGRP-1:0]   gg;
    logic [NGRP-1:0]   gp;
    logic [NGRP:0]     cg;

    assign g = operand1 & operand2;
    assign p = operand1 ^ operand2;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            localparam int B = 4 * gi;

            assign gg[gi] = g[B+3]
                          | (p[B+3] & g[B+2])
                          | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[gi] = &p[B+3:B];

            // In-group carries are fully expanded from the group carry-in.
            assign c[B]   = cg[gi];
            assign c[B+1] = g[B] | (p[B] & cg[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & cg[gi]);
        end
    endgenerate

    always_comb begin
        cg[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
    end

    assign result = p ^ c;
    assign cout   = cg[NGRP];

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 shift-add multiplier with sign-magnitude handling
// and a final two-step negation, all through one shared adder.
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   bus
);

    state_t              state_q, state_d;
    logic [MULT_W-1:0]   mcand_q, mcand_d;
    logic [MULT_W-1:0]   hi_q, hi_d;
    logic [MULT_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                ncarry_q, ncarry_d;

    logic [MULT_W-1:0]   add_a, add_b, add_sum;
    logic                add_cin, add_cout;
    logic                accept;
    logic                calc_last;

    assign accept    = (state_q == ST_IDLE) && bus.mult_valid && !bus.flush;
    assign calc_last = (cnt_q == CNT_W'(MULT_W - 1));

    mult_seq_cla u_adder (
        .operand1 (add_a),
        .operand2 (add_b),
        .cin      (add_cin),
        .result   (add_sum),
        .cout     (add_cout)
    );

    // Adder operand selection: partial-product add, then two-word negation.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_CALC: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
            end
            ST_NEG_LO: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            ST_NEG_HI: begin
                add_a   = ~hi_q;
                add_cin = ncarry_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (accept) state_d = ST_CALC;
                ST_CALC:   if (calc_last) state_d = neg_q ? ST_NEG_LO : ST_DONE;
                ST_NEG_LO: state_d = ST_NEG_HI;
                ST_NEG_HI: state_d = ST_DONE;
                ST_DONE:   if (bus.product_ack) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mult_ready    = (state_q == ST_IDLE);
        bus.product_valid = (state_q == ST_DONE);
        bus.product       = {hi_q, lo_q};
    end

    always_comb begin
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        ncarry_d = ncarry_q;
        if (!bus.flush) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mcand_d = magnitude(bus.mult_op1, bus.mult_signed);
                        lo_d    = magnitude(bus.mult_op2, bus.mult_signed);
                        hi_d    = '0;
                        cnt_d   = '0;
                        neg_d   = bus.mult_signed & (bus.mult_op1[MULT_W-1] ^ bus.mult_op2[MULT_W-1]);
                    end
                end
                ST_CALC: begin
                    // {cout,sum,lo} >> 1; carry only counts when an add happened.
                    hi_d  = {lo_q[0] & add_cout, add_sum[MULT_W-1:1]};
                    lo_d  = {add_sum[0], lo_q[MULT_W-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ST_NEG_LO: begin
                    lo_d     = add_sum;
                    ncarry_d = add_cout;
                end
                ST_NEG_HI: begin
                    hi_d = add_sum;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ncarry_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            ncarry_q <= ncarry_d;
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: vector table for products/latency plus
// hand-written handshake, flush and reset sequences.
module tb_mult_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mult_seq_if bus ();

    mult_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_p;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents one request, returns the product and the edge count from the
    // accept edge (inclusive) to the first cycle with product_valid high.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output int lat);
        @(negedge clk);
        bus.mult_valid  = 1'b1;
        bus.mult_signed = s;
        bus.mult_op1    = a;
        bus.mult_op2    = b;
        @(posedge clk);
        #1;
        bus.mult_valid = 1'b0;
        lat = 1;
        check("busy_ready", {63'd0, bus.mult_ready}, 64'd0);
        while (!bus.product_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = bus.product;
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.product_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.product_ack = 1'b0;
        check("ack_ready", {63'd0, bus.mult_ready}, 64'd1);
        check("ack_valid", {63'd0, bus.product_valid}, 64'd0);
    endtask

    task automatic no_valid_for(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.product_valid) seen = 1'b1;
        end
        check(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        logic [63:0] held;
        int          lat;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{1'b0, 32'h0000000A, 32'h00000003, 64'h000000000000001E, 33};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33};
        vecs[2]  = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, 35};
        vecs[3]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 33};
        vecs[4]  = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 33};
        vecs[5]  = '{1'b1, 32'h00000005, 32'hFFFFFFF9, 64'hFFFFFFFFFFFFFFDD, 35};
        vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 33};
        vecs[7]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 35};
        vecs[8]  = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h0000000000000000, 35};
        vecs[9]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000, 33};
        vecs[10] = '{1'b0, 32'hFFFFFFFE, 32'h00000003, 64'h00000002FFFFFFFA, 33};
        vecs[11] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 33};

        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.mult_valid  = 1'b0;
        bus.mult_signed = 1'b0;
        bus.mult_op1    = '0;
        bus.mult_op2    = '0;
        bus.product_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   {63'd0, bus.mult_ready}, 64'd1);
        check("rst_valid",   {63'd0, bus.product_valid}, 64'd0);
        check("rst_product", bus.product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", {63'd0, bus.mult_ready}, 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
            $display("[TB] vec %0d s=%0d %h*%h -> %h lat=%0d", i, vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
            check("vec_product", p, vecs[i].exp_p);
            check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            do_ack();
        end

        // Product held while the consumer stalls.
        run_op(1'b0, 32'h12345678, 32'h00000010, p, lat);
        check("hold_product0", p, 64'h0000000123456780);
        held = p;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_product", bus.product, held);
            check("hold_ready", {63'd0, bus.mult_ready}, 64'd0);
        end
        $display("[TB] hold 10 cycles product=%h", bus.product);
        do_ack();

        // Busy request is dropped, stray ack before completion is ignored.
        @(negedge clk);
        bus.mult_valid = 1'b1; bus.mult_signed = 1'b0;
        bus.mult_op1 = 32'h0000000A; bus.mult_op2 = 32'h00000003;
        @(posedge clk);
        #1;
        bus.mult_op1 = 32'h00000007; bus.mult_op2 = 32'h00000009;
        repeat (3) @(posedge clk);
        #1;
        bus.mult_valid  = 1'b0;
        bus.product_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.product_ack = 1'b0;
        lat = 5;
        while (!bus.product_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("[TB] busy-drop product=%h lat=%0d", bus.product, lat);
        check("busy_product", bus.product, 64'h000000000000001E);
        check("busy_latency", 64'(lat), 64'd33);
        do_ack();
        no_valid_for("no_queue", 5);

        // Flush at counter 15.
        @(negedge clk);
        bus.mult_valid = 1'b1; bus.mult_signed = 1'b0;
        bus.mult_op1 = 32'hFFFFFFFF; bus.mult_op2 = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.mult_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        $display("[TB] flush at cnt15 ready=%0d valid=%0d", bus.mult_ready, bus.product_valid);
        check("flush_ready", {63'd0, bus.mult_ready}, 64'd1);
        check("flush_valid", {63'd0, bus.product_valid}, 64'd0);
        no_valid_for("flush_no_valid", 40);

        // Flush beats accept in IDLE.
        @(negedge clk);
        bus.flush = 1'b1; bus.mult_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.mult_valid = 1'b0;
        $display("[TB] flush+req in idle ready=%0d", bus.mult_ready);
        check("flush_vs_accept", {63'd0, bus.mult_ready}, 64'd1);
        no_valid_for("flush_idle_no_valid", 40);

        // Flush beats ack in DONE.
        run_op(1'b0, 32'h00000002, 32'h00000002, p, lat);
        check("pre_flush_done", p, 64'd4);
        @(negedge clk);
        bus.flush = 1'b1; bus.product_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.product_ack = 1'b0;
        $display("[TB] flush in done valid=%0d ready=%0d", bus.product_valid, bus.mult_ready);
        check("flush_done_valid", {63'd0, bus.product_valid}, 64'd0);
        check("flush_done_ready", {63'd0, bus.mult_ready}, 64'd1);

        // Async reset during NEG_LO.
        @(negedge clk);
        bus.mult_valid = 1'b1; bus.mult_signed = 1'b1;
        bus.mult_op1 = 32'hFFFFFFFE; bus.mult_op2 = 32'h00000003;
        @(posedge clk);
        #1;
        bus.mult_valid = 1'b0;
        repeat (32) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] rst in NEG_LO product=%h ready=%0d valid=%0d", bus.product, bus.mult_ready, bus.product_valid);
        check("rst_mid_product", bus.product, 64'd0);
        check("rst_mid_ready", {63'd0, bus.mult_ready}, 64'd1);
        check("rst_mid_valid", {63'd0, bus.product_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_valid_for("rst_no_valid", 40);

        run_op(1'b1, 32'hFFFFFFFE, 32'h00000003, p, lat);
        $display("[TB] after rst %h lat=%0d", p, lat);
        check("after_rst_product", p, 64'hFFFFFFFFFFFFFFFA);
        check("after_rst_latency", 64'(lat), 64'd35);
        do_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
